// File: rtl/mac_array_sched.sv
// Column sequencer for the N-lane MAC array: streams M and one X column per frame,
// waits for all lanes to finish, and hands each column of P = M*X out on a ready/valid port.
module mac_array_sched #(
  parameter int N       = 5,
  parameter int WIDTH   = 16,
  parameter int M_WIDTH = 2*WIDTH+N-1,
  parameter int IDX_W   = 3,
  parameter int COL_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [COL_W-1:0]         num_cols,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic                     rd_en,
  output logic [IDX_W-1:0]         a_addr,
  output logic [COL_W+IDX_W-1:0]   b_addr,
  input  logic [N*WIDTH-1:0]       a_rdata,
  input  logic [WIDTH-1:0]         b_rdata,
  output logic                     mac_sof,
  output logic [N*WIDTH-1:0]       mac_a,
  output logic [WIDTH-1:0]         mac_b,
  input  logic [N*M_WIDTH-1:0]     mac_c,
  input  logic [N-1:0]             mac_valid,
  output logic [N*M_WIDTH-1:0]     res_data,
  output logic [COL_W-1:0]         res_col,
  output logic                     res_valid,
  input  logic                     res_ready
);

  localparam int CNT_W = $clog2(TIMEOUT+1);
  localparam logic [IDX_W-1:0] K_LAST = IDX_W'(N-1);
  localparam logic [CNT_W-1:0] W_LAST = CNT_W'(TIMEOUT-1);

  typedef enum logic [1:0] {IDLE, FEED, WAIT, OUT} state_t;

  state_t            state;
  logic [COL_W-1:0]  j;
  logic [COL_W-1:0]  ncols;
  logic [IDX_W-1:0]  k;
  logic [CNT_W-1:0]  wcnt;
  logic              sof_p1;

  assign busy    = (state != IDLE);
  assign rd_en   = (state == FEED);
  assign a_addr  = k;
  assign b_addr  = {j, k};
  assign mac_sof = sof_p1;
  assign mac_a   = a_rdata;
  assign mac_b   = b_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      j         <= '0;
      ncols     <= '0;
      k         <= '0;
      wcnt      <= '0;
      sof_p1    <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_col   <= '0;
    end else begin
      done   <= 1'b0;
      // p1: frame marker lines up with the memory data returned one cycle after rd_en
      sof_p1 <= rd_en && (k == '0);
      case (state)
        IDLE: begin
          if (start) begin
            if (num_cols != '0) begin
              ncols <= num_cols;
              j     <= '0;
              k     <= '0;
              err   <= 1'b0;
              state <= FEED;
            end else begin
              done  <= 1'b1;
            end
          end
        end
        FEED: begin
          if (k == K_LAST) begin
            k     <= '0;
            wcnt  <= '0;
            state <= WAIT;
          end else begin
            k     <= k + IDX_W'(1);
          end
        end
        WAIT: begin
          // a full-valid cycle takes priority over a coincident timeout
          if (&mac_valid) begin
            res_data  <= mac_c;
            res_col   <= j;
            res_valid <= 1'b1;
            state     <= OUT;
          end else if (wcnt == W_LAST) begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            wcnt  <= wcnt + CNT_W'(1);
          end
        end
        OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (j == ncols - COL_W'(1)) begin
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              j     <= j + COL_W'(1);
              state <= FEED;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_array_sched.sv
// Directed bench for mac_array_sched with behavioural memories and a small MAC-array model
// whose results appear two cycles after the last operand beat.
module tb_mac_array_sched;

  localparam int N       = 5;
  localparam int WIDTH   = 16;
  localparam int MW      = 2*WIDTH+N-1;
  localparam int IDX_W   = 3;
  localparam int COL_W   = 4;
  localparam int TIMEOUT = 64;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start;
  logic [COL_W-1:0]        num_cols;
  logic                    busy, done, err, rd_en;
  logic [IDX_W-1:0]        a_addr;
  logic [COL_W+IDX_W-1:0]  b_addr;
  logic [N*WIDTH-1:0]      a_rdata = '0;
  logic [WIDTH-1:0]        b_rdata = '0;
  logic                    mac_sof;
  logic [N*WIDTH-1:0]      mac_a;
  logic [WIDTH-1:0]        mac_b;
  logic [N*MW-1:0]         mac_c = '0;
  logic [N-1:0]            mac_valid = '0;
  logic [N*MW-1:0]         res_data;
  logic [COL_W-1:0]        res_col;
  logic                    res_valid;
  logic                    res_ready;

  mac_array_sched #(.N(N), .WIDTH(WIDTH), .M_WIDTH(MW), .IDX_W(IDX_W),
                    .COL_W(COL_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .num_cols(num_cols),
    .busy(busy), .done(done), .err(err), .rd_en(rd_en),
    .a_addr(a_addr), .b_addr(b_addr), .a_rdata(a_rdata), .b_rdata(b_rdata),
    .mac_sof(mac_sof), .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c),
    .mac_valid(mac_valid), .res_data(res_data), .res_col(res_col),
    .res_valid(res_valid), .res_ready(res_ready)
  );

  always #5 clk = ~clk;

  logic [N*WIDTH-1:0] mem_a [0:(1<<IDX_W)-1];
  logic [WIDTH-1:0]   mem_x [0:(1<<(COL_W+IDX_W))-1];

  always @(posedge clk) begin
    if (rd_en) begin
      a_rdata <= mem_a[a_addr];
      b_rdata <= mem_x[b_addr];
    end
  end

  // Array model: accumulate sof beat plus N-1 following beats, then two register stages.
  logic [MW-1:0] acc [N];
  logic [MW-1:0] c1  [N];
  int            beat = 0;
  logic          v1 = 1'b0;
  logic [N-1:0]  lane_mask;

  always @(posedge clk) begin
    if (mac_sof) begin
      for (int l = 0; l < N; l++) acc[l] <= MW'(mac_a[l*WIDTH +: WIDTH]) * MW'(mac_b);
      beat <= 1;
    end else if (beat > 0 && beat < N) begin
      for (int l = 0; l < N; l++) acc[l] <= acc[l] + MW'(mac_a[l*WIDTH +: WIDTH]) * MW'(mac_b);
      beat <= beat + 1;
    end else begin
      beat <= 0;
    end
    v1 <= (beat == N);
    for (int l = 0; l < N; l++) c1[l] <= acc[l];
    mac_valid <= v1 ? lane_mask : '0;
    for (int l = 0; l < N; l++) mac_c[l*MW +: MW] <= c1[l];
  end

  int   n_rd = 0, n_sof = 0, n_done = 0, n_rv = 0;
  logic rv_q = 1'b0;

  always @(posedge clk) begin
    if (rd_en) n_rd++;
    if (mac_sof) n_sof++;
    if (done) n_done++;
    if (res_valid && !rv_q) n_rv++;
    rv_q = res_valid;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic go(input logic [COL_W-1:0] nc);
    start    = 1'b1;
    num_cols = nc;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic wait_rv(input string tag);
    int n = 0;
    while (res_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(tag, res_valid, 1);
  endtask

  task automatic chk_lanes(input string tag, input int base, input int step);
    for (int l = 0; l < N; l++)
      chk($sformatf("%s_lane%0d", tag, l), res_data[l*MW +: MW], 64'(base + step*l));
  endtask

  task automatic load_identity();
    for (int k = 0; k < (1<<IDX_W); k++) begin
      mem_a[k] = '0;
      if (k < N) mem_a[k][k*WIDTH +: WIDTH] = 16'd1;
    end
    for (int i = 0; i < (1<<(COL_W+IDX_W)); i++) mem_x[i] = 16'd1;
    for (int k = 0; k < N; k++) mem_x[k] = WIDTH'(k+1);
  endtask

  task automatic load_twos();
    for (int k = 0; k < (1<<IDX_W); k++) begin
      mem_a[k] = '0;
      if (k < N)
        for (int l = 0; l < N; l++) mem_a[k][l*WIDTH +: WIDTH] = 16'd2;
    end
    for (int i = 0; i < (1<<(COL_W+IDX_W)); i++) mem_x[i] = 16'd1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s_rd, s_sof, s_done, s_rv, n;
    rst = 1'b1; start = 1'b0; num_cols = '0; res_ready = 1'b0; lane_mask = '1;
    load_identity();

    // reset and idle
    cyc(3);
    chk("rst_busy", busy, 0);
    chk("rst_res_valid", res_valid, 0);
    rst = 1'b0;
    cyc(10);
    chk("idle_busy", busy, 0);
    chk("idle_rd_en", rd_en, 0);
    chk("idle_sof", mac_sof, 0);
    chk("idle_res_valid", res_valid, 0);
    chk("idle_done", done, 0);
    chk("idle_err", err, 0);
    chk("idle_b_addr", b_addr, 0);
    chk("idle_res_data", res_data[63:0], 0);
    chk("idle_res_col", res_col, 0);

    // single column, identity M
    res_ready = 1'b1;
    s_rd = n_rd; s_sof = n_sof; s_done = n_done;
    go(1);
    chk("t1_busy", busy, 1);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("t1_rd_en_k%0d", k), rd_en, 1);
      chk($sformatf("t1_a_addr_k%0d", k), a_addr, k);
      chk($sformatf("t1_b_addr_k%0d", k), b_addr, k);
      chk($sformatf("t1_sof_k%0d", k), mac_sof, (k == 1));
      if (k == 1) begin
        chk("t1_sof_a0", mac_a[WIDTH-1:0], 1);
        chk("t1_sof_b", mac_b, 1);
      end
      @(negedge clk);
    end
    chk("t1_rd_en_off", rd_en, 0);
    wait_rv("t1_rv");
    chk("t1_res_col", res_col, 0);
    chk_lanes("t1", 1, 1);
    @(negedge clk);
    chk("t1_done", done, 1);
    chk("t1_busy_done", busy, 0);
    chk("t1_rv_low", res_valid, 0);
    @(negedge clk);
    chk("t1_done_pulse", done, 0);
    cyc(2);
    chk("t1_rd_count", n_rd - s_rd, N);
    chk("t1_sof_count", n_sof - s_sof, 1);
    chk("t1_done_count", n_done - s_done, 1);
    chk("t1_err", err, 0);

    // three columns with backpressure on column 1 and a stray start
    load_twos();
    s_rd = n_rd; s_done = n_done;
    go(3);
    wait_rv("t2_rv0");
    chk("t2_col0", res_col, 0);
    chk_lanes("t2c0", 10, 0);
    @(negedge clk);
    chk("t2_feed1", rd_en, 1);
    chk("t2_b_addr1", b_addr, 8);
    res_ready = 1'b0;
    wait_rv("t2_rv1");
    chk("t2_col1", res_col, 1);
    chk_lanes("t2c1", 10, 0);
    start = 1'b1; num_cols = 4'd7;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("t2_stall_rv%0d", i), res_valid, 1);
      chk($sformatf("t2_stall_col%0d", i), res_col, 1);
      chk($sformatf("t2_stall_data%0d", i), res_data[4*MW +: MW], 10);
      chk($sformatf("t2_stall_rd%0d", i), rd_en, 0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    chk("t2_feed2", rd_en, 1);
    chk("t2_b_addr2", b_addr, 16);
    chk("t2_rv_drop", res_valid, 0);
    wait_rv("t2_rv2");
    chk("t2_col2", res_col, 2);
    chk_lanes("t2c2", 10, 0);
    @(negedge clk);
    chk("t2_done", done, 1);
    cyc(3);
    chk("t2_rd_count", n_rd - s_rd, 3*N);
    chk("t2_done_count", n_done - s_done, 1);

    // timeout: lane 3 never reports valid
    lane_mask = 5'b10111;
    s_rv = n_rv;
    go(1);
    cyc(N);
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t3_timeout_cycles", n, TIMEOUT);
    chk("t3_err", err, 1);
    chk("t3_busy", busy, 0);
    cyc(3);
    chk("t3_err_sticky", err, 1);
    chk("t3_no_res_valid", n_rv - s_rv, 0);
    lane_mask = '1;
    go(1);
    chk("t3_err_cleared", err, 0);
    wait_rv("t3_rv_good");
    chk_lanes("t3", 10, 0);
    @(negedge clk);
    chk("t3_done_good", done, 1);
    chk("t3_err_good", err, 0);

    // zero columns
    s_rd = n_rd;
    start = 1'b1; num_cols = '0;
    @(negedge clk);
    start = 1'b0;
    chk("t4_done", done, 1);
    chk("t4_busy", busy, 0);
    @(negedge clk);
    chk("t4_done_pulse", done, 0);
    cyc(3);
    chk("t4_no_reads", n_rd - s_rd, 0);

    // reset mid-FEED, then a clean two-column job
    load_identity();
    s_done = n_done; s_rv = n_rv;
    go(2);
    cyc(2);
    chk("t5_k2", a_addr, 2);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_busy", busy, 0);
    chk("t5_rd_en", rd_en, 0);
    rst = 1'b0;
    cyc(12);
    chk("t5_no_done", n_done - s_done, 0);
    chk("t5_no_res", n_rv - s_rv, 0);
    go(2);
    wait_rv("t5_rv0");
    chk("t5_col0", res_col, 0);
    chk_lanes("t5c0", 1, 1);
    @(negedge clk);
    chk("t5_feed1", rd_en, 1);
    wait_rv("t5_rv1");
    chk("t5_col1", res_col, 1);
    chk_lanes("t5c1", 1, 0);
    @(negedge clk);
    chk("t5_done", done, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_array_sched.md
Name: mac_array_sched

Overview:
- Sequencer for the N-lane multiply-accumulate array. It computes P = M·X, where M is N×N and X is N×num_cols.
- For each column j of X, it streams the N columns of M (N×WIDTH words) and the N elements X[k][j] (WIDTH words) from synchronous-read memories into the array, with a frame-start marker.
- It waits for all lanes to report valid, captures the N accumulated results, and presents them on a ready/valid result port, one column at a time.

Parameters:
- N, 5, lanes in the array and the matrix dimension.
- WIDTH, 16, operand width.
- M_WIDTH, 2*WIDTH+N-1, per-lane result width.
- IDX_W, 3, width of the k index; 2^IDX_W >= N.
- COL_W, 4, width of the column index j; at most 2^COL_W-1 columns.
- TIMEOUT, 64, WAIT-state cycle limit before error.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  pulse to begin a job; sampled only in IDLE.
- num_cols  in  COL_W  number of X columns; latched on start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at job end.
- err  out  1  sticky timeout flag; cleared on the next accepted start or on rst.
- rd_en  out  1  memory read strobe.
- a_addr  out  IDX_W  column k of M.
- b_addr  out  COL_W+IDX_W  {j,k} into X storage.
- a_rdata  in  N*WIDTH  M column, returned 1 cycle after rd_en.
- b_rdata  in  WIDTH  X[k][j], returned 1 cycle after rd_en.
- mac_sof  out  1  frame start to the array.
- mac_a  out  N*WIDTH  lane operands to the array; equals a_rdata.
- mac_b  out  WIDTH  broadcast operand to the array; equals b_rdata.
- mac_c  in  N*M_WIDTH  lane results from the array.
- mac_valid  in  N  per-lane valid from the array.
- res_data  out  N*M_WIDTH  captured column of P.
- res_col  out  COL_W  column index j of res_data.
- res_valid  out  1  result available.
- res_ready  in  1  result consumer ready.

Behaviour:
- Reset values:
  - State is IDLE; j=0, k=0, wait counter=0.
  - busy, done, err, rd_en, mac_sof, res_valid are 0.
  - a_addr, b_addr, res_data, res_col are 0.
  - rst mid-job aborts immediately. There is no partial result and no done pulse. An in-flight array frame is ignored.
- IDLE:
  - start=1 with num_cols!=0 latches num_cols, sets j=0 and err=0, and goes to FEED on the next edge.
  - start=1 with num_cols==0 pulses done in the following cycle and stays in IDLE. No reads occur.
  - start is ignored whenever busy=1.
- FEED (exactly N cycles):
  - rd_en=1, a_addr=k, b_addr={j,k}; k runs 0..N-1.
  - mac_sof is rd_en&&(k==0) delayed by one register stage, so it is aligned with the returning data.
  - mac_a and mac_b pass a_rdata and b_rdata through combinationally. The array therefore sees sof plus N valid operand beats, with the first beat in the sof cycle.
  - After k=N-1: k resets to 0, next state is WAIT, wait counter=0.
- WAIT:
  - rd_en=0 and the wait counter increments each cycle.
  - The result is complete only when mac_valid equals all ones in a single cycle; partial valids are ignored.
  - On completion: capture res_data<=mac_c and res_col<=j, set res_valid=1, go to OUT.
  - If the counter reaches TIMEOUT first: set err=1, pulse done, go to IDLE. res_valid stays 0.
  - If completion and the TIMEOUT count coincide in the same cycle, completion wins.
- OUT:
  - res_valid=1 and res_data/res_col are held stable until res_valid&&res_ready.
  - On that handshake res_valid goes to 0 on the next edge.
  - If j==num_cols-1: pulse done and go to IDLE.
  - Otherwise: j<=j+1 and go to FEED.
  - res_ready high before res_valid has no effect.
- Latency for one column, res_ready held high:
  - start edge, then N FEED cycles, then WAIT (array pipeline depth plus 1), then 1 OUT cycle.
  - The next FEED begins the cycle after the handshake.
- done:
  - Asserted in the first IDLE cycle after completion, or after timeout.
  - busy is already 0 in that cycle.
- Width rules:
  - j and k never wrap mid-job.
  - b_addr is {j,k} concatenated: j in the upper COL_W bits, k in the lower IDX_W bits. It is not j*N+k.

Test Plan:
- Reset and idle: hold rst for 3 cycles, then release with start=0 for 10 cycles -> busy, rd_en, mac_sof, res_valid, done all 0.
- Single column (N=5, WIDTH=16, num_cols=1, M=identity, X column [1,2,3,4,5], array model with 2-cycle pipeline, res_ready=1):
  - rd_en high exactly 5 cycles with a_addr 0..4.
  - mac_sof a single pulse aligned with a_addr=0 data.
  - res_data lanes = 1,2,3,4,5; res_col=0.
  - done pulses once; err=0.
- Multi-column with backpressure (num_cols=3, M=all 2s, X columns all 1s, res_ready low for 4 cycles on column 1):
  - Every lane = 10 for each column.
  - res_col sequence 0,1,2.
  - res_data stable while stalled; no FEED for column 2 until the column-1 handshake.
- Timeout (array model never raises mac_valid[3]):
  - err=1 and done pulses TIMEOUT cycles after FEED ends.
  - res_valid never rises.
  - A following good job clears err.
- Zero columns and start while busy:
  - num_cols=0 -> done pulses with no rd_en.
  - start re-pulsed mid-job -> no effect on j, k, or results.
- Reset mid-FEED at k=2:
  - Next cycle busy=0 and rd_en=0.
  - A new job then completes with correct values.
